wb_port_arbiter: RTL and testbench

Shares the register file's single writeback port (rd write and cpsr write) between two writeback requesters. Requester 0 is the execute/ALU result path; requester 1 is the memory/load return path. The block uses valid/ready handshakes and round-robin arbitration. It drives the register file's wb_rd_* and wb_cpsr_* inputs from a registered output stage, and publishes a pending-write mask that execute uses for hazard stalls.

---
 rtl/wb_port_arbiter_if.sv | 40 ++++
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 tb/tb_wb_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: two valid/ready requesters plus the register-file write port.
// The arbiter takes the slave side; whatever drives the requests takes the master side.
interface wb_port_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_rd_num;
  logic        req0_rd_en;
  logic [31:0] req0_rd_data;
  logic        req0_cpsr_en;
  logic [31:0] req0_cpsr_data;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_rd_num;
  logic        req1_rd_en;
  logic [31:0] req1_rd_data;
  logic        req1_cpsr_en;
  logic [31:0] req1_cpsr_data;

  logic [3:0]  wb_rd_num;
  logic        wb_rd_write_en;
  logic [31:0] wb_rd_in;
  logic        wb_cpsr_write_en;
  logic [31:0] wb_cpsr_in;
  logic [15:0] pending_mask;

  modport slave (
    input  req0_valid, req0_rd_num, req0_rd_en, req0_rd_data, req0_cpsr_en, req0_cpsr_data,
    input  req1_valid, req1_rd_num, req1_rd_en, req1_rd_data, req1_cpsr_en, req1_cpsr_data,
    output req0_ready, req1_ready,
    output wb_rd_num, wb_rd_write_en, wb_rd_in, wb_cpsr_write_en, wb_cpsr_in, pending_mask
  );

  modport master (
    output req0_valid, req0_rd_num, req0_rd_en, req0_rd_data, req0_cpsr_en, req0_cpsr_data,
    output req1_valid, req1_rd_num, req1_rd_en, req1_rd_data, req1_cpsr_en, req1_cpsr_data,
    input  req0_ready, req1_ready,
    input  wb_rd_num, wb_rd_write_en, wb_rd_in, wb_cpsr_write_en, wb_cpsr_in, pending_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port between the ALU and load paths.
// Optional macro WB_FORWARD_EN adds a bypass tap (fwd_rd_num / fwd_hit / fwd_data) on the output stage.
module wb_port_arbiter #(
  parameter int RR_INIT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  wb_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] conflict_cnt
`ifdef WB_FORWARD_EN
  ,
  input  logic [3:0]       fwd_rd_num,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data
`endif
);

  logic             rr_ptr_q, rr_ptr_d;
  logic             grant0, grant1, both_valid;
  logic [3:0]       wb_rd_num_q, wb_rd_num_d;
  logic             wb_rd_write_en_q, wb_rd_write_en_d;
  logic [31:0]      wb_rd_in_q, wb_rd_in_d;
  logic             wb_cpsr_write_en_q, wb_cpsr_write_en_d;
  logic [31:0]      wb_cpsr_in_q, wb_cpsr_in_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0]      pending;

  // Grants are gated by reset so no handshake can complete while it is asserted.
  always_comb begin
    both_valid = bus.req0_valid & bus.req1_valid;
    grant0     = reset & bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
    grant1     = reset & bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    rr_ptr_d           = rr_ptr_q;
    wb_rd_num_d        = wb_rd_num_q;
    wb_rd_in_d         = wb_rd_in_q;
    wb_cpsr_in_d       = wb_cpsr_in_q;
    wb_rd_write_en_d   = 1'b0;
    wb_cpsr_write_en_d = 1'b0;
    if (grant0) begin
      rr_ptr_d           = 1'b1;
      wb_rd_num_d        = bus.req0_rd_num;
      wb_rd_in_d         = bus.req0_rd_data;
      wb_cpsr_in_d       = bus.req0_cpsr_data;
      wb_rd_write_en_d   = bus.req0_rd_en;
      wb_cpsr_write_en_d = bus.req0_cpsr_en;
    end else if (grant1) begin
      rr_ptr_d           = 1'b0;
      wb_rd_num_d        = bus.req1_rd_num;
      wb_rd_in_d         = bus.req1_rd_data;
      wb_cpsr_in_d       = bus.req1_cpsr_data;
      wb_rd_write_en_d   = bus.req1_rd_en;
      wb_cpsr_write_en_d = bus.req1_cpsr_en;
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (both_valid && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q           <= 1'(RR_INIT);
      wb_rd_num_q        <= '0;
      wb_rd_write_en_q   <= 1'b0;
      wb_rd_in_q         <= '0;
      wb_cpsr_write_en_q <= 1'b0;
      wb_cpsr_in_q       <= '0;
      conflict_cnt_q     <= '0;
    end else begin
      rr_ptr_q           <= rr_ptr_d;
      wb_rd_num_q        <= wb_rd_num_d;
      wb_rd_write_en_q   <= wb_rd_write_en_d;
      wb_rd_in_q         <= wb_rd_in_d;
      wb_cpsr_write_en_q <= wb_cpsr_write_en_d;
      wb_cpsr_in_q       <= wb_cpsr_in_d;
      conflict_cnt_q     <= conflict_cnt_d;
    end
  end

  // A register stays pending from request until the output stage has written it.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pend
    assign pending[gi] =
        (bus.req0_valid & bus.req0_rd_en & (bus.req0_rd_num == 4'(gi))) |
        (bus.req1_valid & bus.req1_rd_en & (bus.req1_rd_num == 4'(gi))) |
        (wb_rd_write_en_q & (wb_rd_num_q == 4'(gi)));
  end

  assign bus.pending_mask     = pending;
  assign bus.wb_rd_num        = wb_rd_num_q;
  assign bus.wb_rd_write_en   = wb_rd_write_en_q;
  assign bus.wb_rd_in         = wb_rd_in_q;
  assign bus.wb_cpsr_write_en = wb_cpsr_write_en_q;
  assign bus.wb_cpsr_in       = wb_cpsr_in_q;
  assign conflict_cnt         = conflict_cnt_q;

`ifdef WB_FORWARD_EN
  assign fwd_hit  = wb_rd_write_en_q & (wb_rd_num_q == fwd_rd_num);
  assign fwd_data = wb_rd_in_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, alternation/saturation run, random run vs. model.
// Two instances share stimulus: default parameters, and RR_INIT=1 with a 4-bit conflict counter.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();
  wb_port_arbiter_if bus4();
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
`ifdef WB_FORWARD_EN
  logic [3:0]  fwd_num = 4'd0;
  logic        fwd_hit, fwd_hit4;
  logic [31:0] fwd_data, fwd_data4;
`endif

  wb_port_arbiter dut (
    .clk(clk), .reset(reset), .bus(bus), .conflict_cnt(cnt16)
`ifdef WB_FORWARD_EN
    , .fwd_rd_num(fwd_num), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  wb_port_arbiter #(.RR_INIT(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .conflict_cnt(cnt4)
`ifdef WB_FORWARD_EN
    , .fwd_rd_num(fwd_num), .fwd_hit(fwd_hit4), .fwd_data(fwd_data4)
`endif
  );

  assign bus4.req0_valid     = bus.req0_valid;
  assign bus4.req0_rd_num    = bus.req0_rd_num;
  assign bus4.req0_rd_en     = bus.req0_rd_en;
  assign bus4.req0_rd_data   = bus.req0_rd_data;
  assign bus4.req0_cpsr_en   = bus.req0_cpsr_en;
  assign bus4.req0_cpsr_data = bus.req0_cpsr_data;
  assign bus4.req1_valid     = bus.req1_valid;
  assign bus4.req1_rd_num    = bus.req1_rd_num;
  assign bus4.req1_rd_en     = bus.req1_rd_en;
  assign bus4.req1_rd_data   = bus.req1_rd_data;
  assign bus4.req1_cpsr_en   = bus.req1_cpsr_en;
  assign bus4.req1_cpsr_data = bus.req1_cpsr_data;

  typedef struct {
    int v0, n0, e0, d0, c0, cd0;
    int v1, n1, e1, d1, c1, cd1;
    int r0, r1;
    int we, wn, wd, ce, cd, pm, cnt;
  } vec_t;
  vec_t tbl[14];

  int n_chk = 0;
  int n_fail = 0;

  // Requester stimulus, indexed by requester
  int v[2], n[2], e[2], d[2], c[2], cd[2];
  int gr[2];

  // Reference model per instance: priority holder, committed write, conflict count
  int m_ptr[2], m_we[2], m_wn[2], m_wd[2], m_ce[2], m_cd[2], m_cnt[2];
  int cmax[2] = '{65535, 15};
  int rr_init[2] = '{0, 1};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    bus.req0_valid     = (v[0] != 0);
    bus.req0_rd_num    = 4'(n[0]);
    bus.req0_rd_en     = (e[0] != 0);
    bus.req0_rd_data   = d[0];
    bus.req0_cpsr_en   = (c[0] != 0);
    bus.req0_cpsr_data = cd[0];
    bus.req1_valid     = (v[1] != 0);
    bus.req1_rd_num    = 4'(n[1]);
    bus.req1_rd_en     = (e[1] != 0);
    bus.req1_rd_data   = d[1];
    bus.req1_cpsr_en   = (c[1] != 0);
    bus.req1_cpsr_data = cd[1];
  endtask

  task automatic load_row(vec_t t);
    v[0] = t.v0; n[0] = t.n0; e[0] = t.e0; d[0] = t.d0; c[0] = t.c0; cd[0] = t.cd0;
    v[1] = t.v1; n[1] = t.n1; e[1] = t.e1; d[1] = t.d1; c[1] = t.c1; cd[1] = t.cd1;
  endtask

  function automatic int winner(int k);
    if (!reset || (v[0] == 0 && v[1] == 0)) return -1;
    if (v[0] != 0 && v[1] != 0) return m_ptr[k];
    return (v[0] != 0) ? 0 : 1;
  endfunction

  function automatic int exp_pending(int k);
    int pm = 0;
    for (int r = 0; r < 2; r++)
      if (v[r] != 0 && e[r] != 0) pm = pm | (1 << n[r]);
    if (m_we[k] != 0) pm = pm | (1 << m_wn[k]);
    return pm;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = rr_init[k];
      m_we[k] = 0; m_wn[k] = 0; m_wd[k] = 0; m_ce[k] = 0; m_cd[k] = 0; m_cnt[k] = 0;
    end
    gr[0] = 0; gr[1] = 0;
  endtask

  task automatic model_adv(int k);
    int w;
    w = winner(k);
    if (w >= 0) begin
      m_we[k] = e[w]; m_wn[k] = n[w]; m_wd[k] = d[w]; m_ce[k] = c[w]; m_cd[k] = cd[w];
      m_ptr[k] = 1 - w;
    end else begin
      m_we[k] = 0; m_ce[k] = 0;
    end
    if (v[0] != 0 && v[1] != 0 && m_cnt[k] < cmax[k]) m_cnt[k]++;
    if (k == 0) begin
      gr[0] = (w == 0) ? 1 : 0;
      gr[1] = (w == 1) ? 1 : 0;
    end
  endtask

  task automatic check_inst(int k, string tag);
    logic [31:0] a_r0, a_r1, a_we, a_wn, a_wd, a_ce, a_cd, a_pm, a_cnt;
    int w;
    if (k == 0) begin
      a_r0 = 32'(bus.req0_ready); a_r1 = 32'(bus.req1_ready);
      a_we = 32'(bus.wb_rd_write_en); a_wn = 32'(bus.wb_rd_num); a_wd = bus.wb_rd_in;
      a_ce = 32'(bus.wb_cpsr_write_en); a_cd = bus.wb_cpsr_in;
      a_pm = 32'(bus.pending_mask); a_cnt = 32'(cnt16);
    end else begin
      a_r0 = 32'(bus4.req0_ready); a_r1 = 32'(bus4.req1_ready);
      a_we = 32'(bus4.wb_rd_write_en); a_wn = 32'(bus4.wb_rd_num); a_wd = bus4.wb_rd_in;
      a_ce = 32'(bus4.wb_cpsr_write_en); a_cd = bus4.wb_cpsr_in;
      a_pm = 32'(bus4.pending_mask); a_cnt = 32'(cnt4);
    end
    w = winner(k);
    chk($sformatf("%s.i%0d.rdy0", tag, k), a_r0, (w == 0) ? 1 : 0);
    chk($sformatf("%s.i%0d.rdy1", tag, k), a_r1, (w == 1) ? 1 : 0);
    chk($sformatf("%s.i%0d.wb_rd_write_en", tag, k), a_we, m_we[k]);
    chk($sformatf("%s.i%0d.wb_rd_num", tag, k), a_wn, m_wn[k]);
    chk($sformatf("%s.i%0d.wb_rd_in", tag, k), a_wd, m_wd[k]);
    chk($sformatf("%s.i%0d.wb_cpsr_write_en", tag, k), a_ce, m_ce[k]);
    chk($sformatf("%s.i%0d.wb_cpsr_in", tag, k), a_cd, m_cd[k]);
    chk($sformatf("%s.i%0d.pending_mask", tag, k), a_pm, exp_pending(k));
    chk($sformatf("%s.i%0d.conflict_cnt", tag, k), a_cnt, m_cnt[k]);
`ifdef WB_FORWARD_EN
    if (k == 0) begin
      chk($sformatf("%s.fwd_hit", tag), 32'(fwd_hit),
          (m_we[0] != 0 && m_wn[0] == int'(fwd_num)) ? 1 : 0);
      chk($sformatf("%s.fwd_data", tag), fwd_data, m_wd[0]);
    end
`endif
  endtask

  task automatic eval_cycle(string tag);
    check_inst(0, tag);
    check_inst(1, tag);
    model_adv(1);
    model_adv(0);
  endtask

  task automatic run_cycle(string tag);
    drive();
    @(negedge clk);
    eval_cycle(tag);
    @(posedge clk); #1;
  endtask

  task automatic new_req(int r, int force_valid);
    v[r]  = (force_valid != 0 || $urandom_range(3) != 0) ? 1 : 0;
    n[r]  = int'($urandom_range(15));
    e[r]  = ($urandom_range(3) != 0) ? 1 : 0;
    d[r]  = int'($urandom);
    c[r]  = ($urandom_range(3) == 0) ? 1 : 0;
    cd[r] = int'($urandom);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      v[r] = 0; n[r] = 0; e[r] = 0; d[r] = 0; c[r] = 0; cd[r] = 0;
    end
    drive();
    @(posedge clk); #2;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    //           v0 n0 e0 d0     c0 cd0  v1 n1 e1 d1      c1 cd1           r0 r1 we wn wd      ce cd            pm       cnt
    tbl[0]  = '{1, 3, 1, 'h11,  0, 0,   1, 3, 1, 'h22,   0, 0,            1, 0, 0, 0, 0,      0, 0,            'h0008, 0};
    tbl[1]  = '{0, 3, 1, 'h11,  0, 0,   1, 3, 1, 'h22,   0, 0,            0, 1, 1, 3, 'h11,   0, 0,            'h0008, 1};
    tbl[2]  = '{0, 0, 0, 0,     0, 0,   0, 0, 0, 0,      0, 0,            0, 0, 1, 3, 'h22,   0, 0,            'h0008, 1};
    tbl[3]  = '{0, 0, 0, 0,     0, 0,   1, 7, 0, 'hDEAD, 1, 'hF0000000,   0, 1, 0, 3, 'h22,   0, 0,            'h0000, 1};
    tbl[4]  = '{1, 5, 1, 'h55,  0, 0,   0, 0, 0, 0,      0, 0,            1, 0, 0, 7, 'hDEAD, 1, 'hF0000000,   'h0020, 1};
    tbl[5]  = '{1, 2, 1, 'h02,  0, 0,   0, 0, 0, 0,      0, 0,            1, 0, 1, 5, 'h55,   0, 0,            'h0024, 1};
    tbl[6]  = '{1, 5, 1, 'h66,  0, 0,   0, 0, 0, 0,      0, 0,            1, 0, 1, 2, 'h02,   0, 0,            'h0024, 1};
    tbl[7]  = '{0, 0, 0, 0,     0, 0,   0, 0, 0, 0,      0, 0,            0, 0, 1, 5, 'h66,   0, 0,            'h0020, 1};
    tbl[8]  = '{0, 0, 0, 0,     0, 0,   0, 0, 0, 0,      0, 0,            0, 0, 0, 5, 'h66,   0, 0,            'h0000, 1};
    tbl[9]  = '{1, 1, 1, 'hA0,  0, 0,   1, 4, 1, 'hB0,   0, 0,            0, 1, 0, 5, 'h66,   0, 0,            'h0012, 1};
    tbl[10] = '{1, 1, 1, 'hA0,  0, 0,   1, 4, 1, 'hB1,   0, 0,            1, 0, 1, 4, 'hB0,   0, 0,            'h0012, 2};
    tbl[11] = '{1, 1, 1, 'hA1,  0, 0,   1, 4, 1, 'hB1,   0, 0,            0, 1, 1, 1, 'hA0,   0, 0,            'h0012, 3};
    tbl[12] = '{0, 0, 0, 0,     0, 0,   0, 0, 0, 0,      0, 0,            0, 0, 1, 4, 'hB1,   0, 0,            'h0010, 4};
    tbl[13] = '{0, 0, 0, 0,     0, 0,   0, 0, 0, 0,      0, 0,            0, 0, 0, 4, 'hB1,   0, 0,            'h0000, 4};

`ifdef WB_FORWARD_EN
    fwd_num = 4'd5;
`endif
    model_reset();

    // Held in reset with req0 valid: no ready, outputs cleared.
    load_row(tbl[0]);
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy0", 32'(bus.req0_ready), 0);
    chk("rst.rdy1", 32'(bus.req1_ready), 0);
    chk("rst.wb_rd_write_en", 32'(bus.wb_rd_write_en), 0);
    chk("rst.wb_rd_num", 32'(bus.wb_rd_num), 0);
    chk("rst.wb_rd_in", bus.wb_rd_in, 0);
    chk("rst.wb_cpsr_write_en", 32'(bus.wb_cpsr_write_en), 0);
    chk("rst.wb_cpsr_in", bus.wb_cpsr_in, 0);
    chk("rst.conflict_cnt", 32'(cnt16), 0);
    @(posedge clk); #2;
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      load_row(tbl[i]);
      drive();
      @(negedge clk);
      chk($sformatf("vec%0d.rdy0", i), 32'(bus.req0_ready), tbl[i].r0);
      chk($sformatf("vec%0d.rdy1", i), 32'(bus.req1_ready), tbl[i].r1);
      chk($sformatf("vec%0d.wb_rd_write_en", i), 32'(bus.wb_rd_write_en), tbl[i].we);
      chk($sformatf("vec%0d.wb_rd_num", i), 32'(bus.wb_rd_num), tbl[i].wn);
      chk($sformatf("vec%0d.wb_rd_in", i), bus.wb_rd_in, tbl[i].wd);
      chk($sformatf("vec%0d.wb_cpsr_write_en", i), 32'(bus.wb_cpsr_write_en), tbl[i].ce);
      chk($sformatf("vec%0d.wb_cpsr_in", i), bus.wb_cpsr_in, tbl[i].cd);
      chk($sformatf("vec%0d.pending_mask", i), 32'(bus.pending_mask), tbl[i].pm);
      chk($sformatf("vec%0d.conflict_cnt", i), 32'(cnt16), tbl[i].cnt);
`ifdef WB_FORWARD_EN
      chk($sformatf("vec%0d.fwd_hit", i), 32'(fwd_hit), (tbl[i].we != 0 && tbl[i].wn == 5) ? 1 : 0);
      chk($sformatf("vec%0d.fwd_data", i), fwd_data, tbl[i].wd);
`endif
      @(posedge clk); #1;
    end

    // Both requesters always valid: strict alternation, 4-bit counter saturates at 15.
    reset_pulse();
    for (int i = 0; i < 22; i++) begin
      for (int r = 0; r < 2; r++)
        if (v[r] == 0 || gr[r] != 0) new_req(r, 1);
      drive();
      @(negedge clk);
      chk($sformatf("alt%0d.rdy0", i), 32'(bus.req0_ready), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d.rdy1", i), 32'(bus.req1_ready), (i % 2 == 1) ? 1 : 0);
      chk($sformatf("sat%0d.cnt4", i), 32'(cnt4), (i < 15) ? i : 15);
      eval_cycle($sformatf("alt%0d", i));
      @(posedge clk); #1;
    end

    // Random traffic, with one asynchronous reset landing on an in-flight write.
    reset_pulse();
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        v[0] = 1; n[0] = 9; e[0] = 1; d[0] = 'h1234; c[0] = 1; cd[0] = 'h5678;
        v[1] = 0;
        run_cycle("pre_rst");
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("midrst.wb_rd_write_en", 32'(bus.wb_rd_write_en), 0);
        chk("midrst.wb_cpsr_write_en", 32'(bus.wb_cpsr_write_en), 0);
        chk("midrst.rdy0", 32'(bus.req0_ready), 0);
        chk("midrst.i1.wb_rd_write_en", 32'(bus4.wb_rd_write_en), 0);
        chk("midrst.i1.rdy0", 32'(bus4.req0_ready), 0);
        model_reset();
        @(posedge clk); #2;
        reset = 1'b1;
      end
      for (int r = 0; r < 2; r++)
        if (v[r] == 0 || gr[r] != 0) new_req(r, 0);
`ifdef WB_FORWARD_EN
      fwd_num = ($urandom_range(1) != 0) ? 4'(m_wn[0]) : 4'($urandom_range(15));
`endif
      run_cycle($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
